pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Upstream feeder for the tone generator's register-write port (write_strobe / address[2:0] / data[4:0]).
- Stores a short pattern of register writes. Each entry is {address[2:0], data[4:0]}.
- On start, replays the entries one by one at a programmable tempo, so notes and effects play without an external controller toggling pins.
- Runs on the system clock, gated by a tick enable (scaled-clock enable), and stretches each strobe so the slower generator reliably samples it.

Parameters:
- STEPS, 8, number of pattern entries (power of two, 2..16).
- TEMPO_W, 8, width of tempo counter/input.
- STROBE_TICKS, 2, en ticks that write_strobe is held high (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- en  in  1  tick enable; all sequencing timers advance only on clk edges with en=1.
- cfg_we  in  1  pattern write enable (not en-gated).
- cfg_addr  in  $clog2(STEPS)  pattern entry index.
- cfg_data  in  8  entry value {address[2:0], data[4:0]}.
- seq_len  in  $clog2(STEPS)+1  steps to play; 0 or >STEPS treated as STEPS; sampled at start.
- tempo  in  TEMPO_W  WAIT length in en ticks; 0 treated as 1; sampled at start.
- loop  in  1  1 = wrap after last step; sampled at start.
- start  in  1  level, sampled on clk in IDLE.
- stop  in  1  level, any state.
- write_strobe  out  1  to generator write_strobe.
- address  out  3  to generator address.
- data  out  5  to generator data.
- busy  out  1  high in any state except IDLE.
- step_idx  out  $clog2(STEPS)  current step.
- done  out  1  one-clk pulse on natural end of a non-loop sequence.

Behaviour:
- Reset, synchronous, dominates all inputs:
  - state=IDLE.
  - write_strobe, address, data, busy, step_idx, done = 0.
  - All pattern entries cleared to 0.
- Pattern write: on clk with cfg_we=1, mem[cfg_addr]=cfg_data.
  - Allowed while running.
  - address/data are registered at SETUP entry, so a write to the active step affects only its next play.
- IDLE:
  - strobe=0; address/data keep their last values.
  - start=1 and stop=0 → latch seq_len, tempo, loop; step_idx=0; load address/data from mem[0]; go to SETUP.
  - start and stop both high: stop wins, stay IDLE.
- SETUP: strobe=0, 1 en tick (address/data setup) → STROBE.
- STROBE: strobe=1 for STROBE_TICKS en ticks → HOLD.
- HOLD: strobe=0, 1 en tick (hold) → WAIT; timer=tempo.
- WAIT: timer decrements per en tick; on expiry:
  - step_idx < len-1: step_idx+1, load mem[step_idx+1], go to SETUP.
  - Last step, loop=1: step_idx=0, load mem[0], go to SETUP.
  - Last step, loop=0: go to IDLE; done=1 for one clk.
- Step period is 1+STROBE_TICKS+1+tempo en ticks. With len=1 and loop=1 the same entry repeats.
- stop=1:
  - In SETUP or WAIT: next clk → IDLE, no done.
  - In STROBE or HOLD: latch stop_pending and finish STROBE and HOLD (no runt strobe), then go to IDLE instead of WAIT, no done.
- start while busy is ignored. Parameters latched at start do not change mid-run.
- en=0 freezes all timers and states; done, stop and cfg writes still act on clk.
- A strobe pulse is never shorter than STROBE_TICKS en ticks, and address/data never change while strobe=1.

Test Plan:
- Basic, en=1, counted from the start-sampling edge = 0:
  - Stimulus: mem[0]=0x2A, mem[1]=0x43, seq_len=2, tempo=3, loop=0, start pulse.
  - Required: address=1/data=10 from cycle 1; strobe high cycles 2-3; address=2/data=3 from cycle 8; strobe high cycles 9-10; done pulse at cycle 15; busy low from cycle 15.
- Loop, seq_len=2, loop=1: step_idx sequence 0,1,0,1…; period 7; no done.
- Stop during STROBE of step 0: strobe still high for 2 ticks, HOLD completes, then IDLE; done stays 0; busy drops after HOLD.
- Stop during WAIT: IDLE on the next clk; a start then restarts at step 0 with newly sampled tempo.
- en toggling 1-of-4 with tempo=0: timings scale 4x; strobe width equals 2 en ticks; WAIT lasts 1 tick.
- Synchronous rst asserted mid-STROBE: outputs 0 on the next edge; mem cleared (readback via a replay plays 0x00); start+stop together in IDLE keeps busy=0.

Source files
------------

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: replays a small pattern of register writes
// {address[2:0], data[4:0]} into the tone generator's write port at a
// programmable tempo. Every write is framed as SETUP (1 tick), STROBE
// (STROBE_TICKS ticks), HOLD (1 tick) and WAIT (tempo ticks), so the slower
// generator always sees a stable address/data around a full-width strobe.
// All sequencing timers advance only on clk edges where en=1.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              tick enable for timers and state changes
//   cfg_we/addr/data  pattern memory write port (not en-gated)
//   seq_len, tempo, loop  run parameters, captured at start
//   start, stop     run control (stop wins over start)
//   write_strobe, address, data  to the generator's register port
//   busy, step_idx, done  status; done pulses one clk on natural end
module pattern_sequencer #(
  parameter int STEPS        = 8,
  parameter int TEMPO_W      = 8,
  parameter int STROBE_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [7:0]               cfg_data,
  input  logic [$clog2(STEPS):0]   seq_len,
  input  logic [TEMPO_W-1:0]       tempo,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic                     write_strobe,
  output logic [2:0]               address,
  output logic [4:0]               data,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done
);

  localparam int IW = $clog2(STEPS);
  localparam int SW = $clog2(STROBE_TICKS + 1);
  localparam logic [IW:0] STEPS_L = (IW+1)'(STEPS);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} state_t;

  state_t             state, nxt;
  logic [7:0]         mem [STEPS];
  logic [IW-1:0]      len_m1;
  logic [TEMPO_W-1:0] tempo_q;
  logic               loop_q;
  logic [TEMPO_W-1:0] timer;
  logic [SW-1:0]      stb_cnt;
  logic               stop_pend;

  logic               load;
  logic [IW-1:0]      load_idx;
  logic               fin;
  logic [IW-1:0]      len_m1_in;
  logic [TEMPO_W-1:0] tempo_in;

  // Out-of-range lengths play the whole pattern; tempo 0 still waits a tick.
  assign len_m1_in = (seq_len == '0 || seq_len > STEPS_L) ? IW'(STEPS - 1)
                                                          : IW'(seq_len - 1'b1);
  assign tempo_in  = (tempo == '0) ? TEMPO_W'(1) : tempo;

  assign write_strobe = (state == STROBE);
  assign busy         = (state != IDLE);

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_idx = '0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (en && start && !stop) begin
          nxt  = SETUP;
          load = 1'b1;
        end
      end
      SETUP: begin
        if (stop)    nxt = IDLE;
        else if (en) nxt = STROBE;
      end
      // stop is deferred here so the strobe is never cut short
      STROBE: begin
        if (en && stb_cnt == '0) nxt = HOLD;
      end
      HOLD: begin
        if (en) nxt = (stop_pend || stop) ? IDLE : WAIT;
      end
      WAIT: begin
        if (stop) begin
          nxt = IDLE;
        end else if (en && timer == TEMPO_W'(1)) begin
          if (step_idx != len_m1) begin
            nxt      = SETUP;
            load     = 1'b1;
            load_idx = step_idx + 1'b1;
          end else if (loop_q) begin
            nxt  = SETUP;
            load = 1'b1;
          end else begin
            nxt = IDLE;
            fin = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      address   <= '0;
      data      <= '0;
      step_idx  <= '0;
      done      <= 1'b0;
      len_m1    <= '0;
      tempo_q   <= '0;
      loop_q    <= 1'b0;
      timer     <= '0;
      stb_cnt   <= '0;
      stop_pend <= 1'b0;
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      done  <= fin;

      if (cfg_we) mem[cfg_addr] <= cfg_data;

      if (state == IDLE && nxt == SETUP) begin
        len_m1  <= len_m1_in;
        tempo_q <= tempo_in;
        loop_q  <= loop;
      end

      // Entry is captured on entering SETUP, so it cannot move under a strobe.
      if (load) begin
        step_idx        <= load_idx;
        {address, data} <= mem[load_idx];
      end

      if (state == SETUP && en)
        stb_cnt <= SW'(STROBE_TICKS - 1);
      else if (state == STROBE && en && stb_cnt != '0)
        stb_cnt <= stb_cnt - 1'b1;

      if (state == HOLD && en)
        timer <= tempo_q;
      else if (state == WAIT && en)
        timer <= timer - 1'b1;

      if (nxt == IDLE)
        stop_pend <= 1'b0;
      else if (stop && (state == STROBE || state == HOLD))
        stop_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer. Stimulus pushes the expected strobe/done/idle
// events of each run into a queue; a monitor on the falling edge pops and
// compares whenever the DUT shows one. Gaps are measured in en ticks.
module tb_pattern_sequencer;

  localparam int STEPS = 8;
  localparam int TW    = 8;
  localparam int ST    = 2;

  localparam int K_STB  = 0;
  localparam int K_DONE = 1;
  localparam int K_IDLE = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
    int idx;
    int gap;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic [3:0]    seq_len = '0;
  logic [TW-1:0] tempo = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          write_strobe;
  logic [2:0]    address;
  logic [4:0]    data;
  logic          busy;
  logic [2:0]    step_idx;
  logic          done;

  pattern_sequencer #(.STEPS(STEPS), .TEMPO_W(TW), .STROBE_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .seq_len(seq_len), .tempo(tempo), .loop(loop),
    .start(start), .stop(stop), .write_strobe(write_strobe),
    .address(address), .data(data), .busy(busy), .step_idx(step_idx),
    .done(done)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   failed = 0;
  ev_t  q[$];
  logic [7:0] mem_m [STEPS];
  int   tick = 0;
  logic rst_edge = 1'b0;
  int   en_mode = 0;
  int   cyc = 0;
  int   stb_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    failed++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // tick count and reset marker, sampled at the active edge
  always @(posedge clk) begin
    rst_edge = rst;
    if (en === 1'b1) tick++;
  end

  // tick enable pattern: always, 1-of-4, or random
  always @(posedge clk) begin
    #1;
    case (en_mode)
      0:       en = 1'b1;
      1:       en = (cyc % 4 == 0);
      default: en = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  end

  // ---------------- monitor ----------------
  logic prev_stb = 1'b0;
  logic prev_busy = 1'b0;
  int   last_tick = 0;
  int   rise_tick = 0;
  logic [7:0] held = '0;
  ev_t  e;

  always @(negedge clk) begin
    if (rst_edge) begin
      prev_stb  = write_strobe;
      prev_busy = busy;
    end else begin
      if (busy && !prev_busy) begin
        last_tick = tick;
        if (q.size() > 0 && q[0].kind == K_STB) begin
          chk("setup_addr", 32'(address), 32'(q[0].addr));
          chk("setup_data", 32'(data), 32'(q[0].data));
        end
      end
      if (write_strobe && !prev_stb) begin
        stb_seen++;
        if (q.size() == 0) timeout("unexpected_strobe");
        else begin
          e = q.pop_front();
          chk("stb_kind", 32'(e.kind), 32'(K_STB));
          chk("stb_addr", 32'(address), 32'(e.addr));
          chk("stb_data", 32'(data), 32'(e.data));
          chk("stb_idx", 32'(step_idx), 32'(e.idx));
          if (e.gap >= 0) chk("stb_gap", 32'(tick - last_tick), 32'(e.gap));
        end
        last_tick = tick;
        rise_tick = tick;
        held = {address, data};
      end else if (write_strobe && prev_stb) begin
        chk("stb_stable", 32'({address, data}), 32'(held));
      end else if (!write_strobe && prev_stb) begin
        chk("stb_width", 32'(tick - rise_tick), 32'(ST));
      end
      if (done) begin
        if (q.size() == 0) timeout("unexpected_done");
        else begin
          e = q.pop_front();
          chk("done_kind", 32'(e.kind), 32'(K_DONE));
          chk("done_gap", 32'(tick - last_tick), 32'(e.gap));
        end
      end
      if (!busy && prev_busy) begin
        if (q.size() == 0) timeout("unexpected_idle");
        else begin
          e = q.pop_front();
          chk("idle_kind", 32'(e.kind), 32'(K_IDLE));
          if (e.gap >= 0) chk("idle_gap", 32'(tick - last_tick), 32'(e.gap));
        end
      end
      prev_stb  = write_strobe;
      prev_busy = busy;
    end
  end

  // ---------------- reference model ----------------
  function automatic int len_eff(input int sl);
    return (sl == 0 || sl > STEPS) ? STEPS : sl;
  endfunction

  task automatic push_ev(input int kind, input int idx, input int gap);
    ev_t x;
    x.kind = kind;
    x.idx  = idx;
    x.addr = int'(mem_m[idx][7:5]);
    x.data = int'(mem_m[idx][4:0]);
    x.gap  = gap;
    q.push_back(x);
  endtask

  // mode 0: natural end; 1: stop during the nstb-th strobe; 2: stop in WAIT
  task automatic push_run(input int sl, input int tp, input int mode, input int nstb);
    int le, te, per, n;
    le  = len_eff(sl);
    te  = (tp == 0) ? 1 : tp;
    per = 1 + ST + 1 + te;
    n   = (mode == 0) ? le : nstb;
    for (int i = 0; i < n; i++) push_ev(K_STB, i % le, (i == 0) ? 1 : per);
    if (mode == 0) begin
      push_ev(K_DONE, 0, ST + 1 + te);
      push_ev(K_IDLE, 0, ST + 1 + te);
    end else begin
      push_ev(K_IDLE, 0, (mode == 1) ? ST + 1 : -1);
    end
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 8'(d);
    step();
    cfg_we   = 1'b0;
    mem_m[a] = 8'(d);
  endtask

  task automatic do_run(input int sl, input int tp, input int lp, input int mode, input int nstb);
    int base, k;
    base = stb_seen;
    push_run(sl, tp, mode, nstb);
    seq_len = 4'(sl);
    tempo   = TW'(tp);
    loop    = 1'(lp);
    start   = 1'b1;
    for (k = 0; k < 200 && !busy; k++) step();
    if (!busy) timeout("start_busy");
    start = 1'b0;
    if (mode != 0) begin
      for (k = 0; k < 4000 && stb_seen < base + nstb; k++) step();
      if (stb_seen < base + nstb) timeout("reach_stop_point");
      if (mode == 2) repeat (4) step();
      stop = 1'b1;
      if (mode == 1) begin
        for (k = 0; k < 400 && busy; k++) step();
      end else begin
        step();
      end
      stop = 1'b0;
    end
    for (k = 0; k < 4000 && q.size() != 0; k++) step();
    if (q.size() != 0) begin
      timeout("drain");
      q.delete();
    end
    repeat (3) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sl, tp, lp, le;
    for (int i = 0; i < STEPS; i++) mem_m[i] = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_strobe", 32'(write_strobe), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step_idx", 32'(step_idx), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();

    // basic two-step sequence at full rate
    cfg_write(0, 8'h2A);
    cfg_write(1, 8'h43);
    do_run(2, 3, 0, 0, 0);

    // loop, then stop inside a strobe
    do_run(2, 3, 1, 1, 5);
    // stop during the first strobe
    do_run(2, 3, 0, 1, 1);
    // stop during WAIT, then restart with a new tempo
    do_run(2, 5, 0, 2, 1);
    do_run(1, 2, 0, 0, 0);

    // slowed tick enable, tempo 0
    en_mode = 1;
    do_run(2, 0, 0, 0, 0);
    en_mode = 0;
    step();

    // reset in the middle of a strobe
    push_ev(K_STB, 0, 1);
    seq_len = 4'd2;
    tempo   = TW'(3);
    loop    = 1'b0;
    start   = 1'b1;
    begin
      int k;
      int base;
      base = stb_seen;
      for (k = 0; k < 200 && stb_seen == base; k++) step();
      if (stb_seen == base) timeout("reset_run_strobe");
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_strobe", 32'(write_strobe), 0);
    chk("mid_rst_address", 32'(address), 0);
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_step_idx", 32'(step_idx), 0);
    rst = 1'b0;
    for (int i = 0; i < STEPS; i++) mem_m[i] = '0;
    if (q.size() != 0) begin
      timeout("pre_reset_events");
      q.delete();
    end
    step();
    // start and stop together: stays idle
    start = 1'b1;
    stop  = 1'b1;
    repeat (5) begin
      step();
      chk("start_stop_busy", 32'(busy), 0);
    end
    start = 1'b0;
    stop  = 1'b0;
    step();
    // replay of a cleared entry
    do_run(1, 1, 0, 0, 0);

    // randomized runs
    for (int it = 0; it < 12; it++) begin
      en_mode = $urandom_range(0, 2);
      repeat ($urandom_range(1, 4)) cfg_write($urandom_range(0, STEPS - 1), $urandom_range(0, 255));
      sl = $urandom_range(0, 15);
      tp = $urandom_range(0, 4);
      lp = $urandom_range(0, 1);
      le = len_eff(sl);
      if (lp == 1)                       do_run(sl, tp, 1, 1, $urandom_range(1, 2 * le));
      else if ($urandom_range(0, 3) == 0) do_run(sl, tp, 0, 1, $urandom_range(1, le));
      else                               do_run(sl, tp, 0, 0, 0);
    end

    en_mode = 0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
